pwm_duty_decoder: RTL and testbench

Receive-side counterpart to the team's PWM generator. It samples an incoming PWM waveform, measures the period and high time in `clk` cycles, and reports the duty cycle on the generator's 0..10 scale in tenths. It sits at the input pad path to close the loop on generated PWM, or to decode externally supplied PWM control signals. It reports stuck-high and stuck-low lines via a timeout.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_duty_decoder_if.sv | 26 ++
 rtl/pwm_sync_edge.sv | 30 +++
 rtl/pwm_duty_decoder.sv | 180 ++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Scale constants and FSM encoding shared by the PWM generator and decoder.
package pwm_pkg;

  localparam int DUTY_STEPS = 10;
  localparam int DUTY_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// Control, PWM input and measurement results of the duty decoder.
interface pwm_duty_decoder_if #(
  parameter int CNT_W = 16
);
  import pwm_pkg::*;

  logic              ena;
  logic              ui_pwm_in;
  logic [DUTY_W-1:0] uo_duty;
  logic [CNT_W-1:0]  uo_period;
  logic [CNT_W-1:0]  uo_high;
  logic              uo_valid;
  logic              uo_overrun;
  logic              uo_timeout;

  modport master (
    output ena, ui_pwm_in,
    input  uo_duty, uo_period, uo_high, uo_valid, uo_overrun, uo_timeout
  );

  modport slave (
    input  ena, ui_pwm_in,
    output uo_duty, uo_period, uo_high, uo_valid, uo_overrun, uo_timeout
  );

endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM pin plus rising-edge detect.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pwm_i,
  output logic s_o,
  output logic rise_o
);

  logic meta_q;
  logic s_q;
  logic s_dly_q;

  // NOTE: flops are written with <= so every stage samples the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      meta_q  <= pwm_i;
      s_q     <= meta_q;
      s_dly_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_dly_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of a PWM input and reports the rounded duty
// in tenths via a 4-step restoring divider; flags stuck lines by timeout.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input logic               clk,
  input logic               rst,
  pwm_duty_decoder_if.slave bus
);

  localparam int                NUM_W     = CNT_W + 4;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(DUTY_STEPS);

  logic s;
  logic rise;

  pwm_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_i  (bus.ui_pwm_in),
    .s_o    (s),
    .rise_o (rise)
  );

  state_e            state_q,    state_d;
  logic              armed_q,    armed_d;
  logic              to_fired_q, to_fired_d;
  logic [CNT_W-1:0]  per_cnt_q,  per_cnt_d;
  logic [CNT_W-1:0]  hi_cnt_q,   hi_cnt_d;
  logic [CNT_W-1:0]  p_q,        p_d;
  logic [CNT_W-1:0]  h_q,        h_d;
  logic [NUM_W-1:0]  rem_q,      rem_d;
  logic [DUTY_W-1:0] quo_q,      quo_d;
  logic [1:0]        bit_idx_q,  bit_idx_d;
  logic [DUTY_W-1:0] duty_q,     duty_d;
  logic [CNT_W-1:0]  period_q,   period_d;
  logic [CNT_W-1:0]  high_q,     high_d;
  logic              valid_q,    valid_d;
  logic              overrun_q,  overrun_d;
  logic              timeout_q,  timeout_d;

  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] hi_inc;
  logic [NUM_W-1:0] num;
  logic [NUM_W-1:0] div_sub;
  logic             div_ge;

  assign per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1);
  assign hi_inc  = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);

  // Adding P/2 before the floor division rounds the duty to the nearest tenth.
  assign num     = NUM_W'(hi_cnt_q) * NUM_W'(DUTY_STEPS) + NUM_W'(per_cnt_q >> 1);
  assign div_sub = NUM_W'(p_q) << bit_idx_q;
  assign div_ge  = (rem_q >= div_sub);

  always_comb begin
    // NOTE: every *_d takes its hold value first so no path can infer a latch.
    state_d    = state_q;
    armed_d    = armed_q;
    to_fired_d = to_fired_q;
    per_cnt_d  = per_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    p_d        = p_q;
    h_d        = h_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    bit_idx_d  = bit_idx_q;
    duty_d     = duty_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;

    if (bus.ena) begin
      if (rise) begin
        per_cnt_d  = CNT_W'(1);
        hi_cnt_d   = CNT_W'(1);
        to_fired_d = 1'b0;
      end else begin
        per_cnt_d = per_inc;
        if (s) hi_cnt_d = hi_inc;
      end

      case (state_q)
        IDLE: begin
          if (rise) begin
            if (!armed_q) begin
              armed_d = 1'b1;
            end else begin
              p_d       = per_cnt_q;
              h_d       = hi_cnt_q;
              rem_d     = num;
              quo_d     = '0;
              bit_idx_d = 2'd3;
              state_d   = DIV;
            end
          end else if (per_cnt_q == CNT_MAX && !to_fired_q) begin
            // A saturated counter stays put, so to_fired_q limits this to one report.
            duty_d     = s ? DUTY_FULL : '0;
            period_d   = '0;
            high_d     = '0;
            valid_d    = 1'b1;
            timeout_d  = 1'b1;
            armed_d    = 1'b0;
            to_fired_d = 1'b1;
          end
        end
        DIV: begin
          if (rise) overrun_d = 1'b1;
          if (div_ge) begin
            rem_d             = rem_q - div_sub;
            quo_d[bit_idx_q]  = 1'b1;
          end
          if (bit_idx_q == 2'd0) begin
            state_d  = IDLE;
            duty_d   = quo_d;
            period_d = p_q;
            high_d   = h_q;
            valid_d  = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q - 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are reset too; the result outputs must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      to_fired_q <= 1'b0;
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      p_q        <= '0;
      h_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      bit_idx_q  <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      to_fired_q <= to_fired_d;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      p_q        <= p_d;
      h_q        <= h_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      bit_idx_q  <= bit_idx_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.uo_duty    = duty_q;
  assign bus.uo_period  = period_q;
  assign bus.uo_high    = high_q;
  assign bus.uo_valid   = valid_q;
  assign bus.uo_overrun = overrun_q;
  assign bus.uo_timeout = timeout_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized scoreboard bench for pwm_duty_decoder: a timestamp-level model of
// the synchronized input predicts every result, overrun and timeout pulse.
module tb_pwm_duty_decoder;

  localparam int CNT_W = 16;
  localparam int TO    = 100;
  localparam int HIST  = 32768;

  typedef struct {
    int cyc;
    int duty;
    int per;
    int hi;
    bit tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  pwm_duty_decoder_if #(.CNT_W(CNT_W)) dut_if ();

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  int   tmo_seen = 0;
  int   ovr_seen = 0;
  bit   sb_on = 1'b0;
  bit   model_on = 1'b0;
  bit   pin_hist [HIST];
  exp_t vq[$];
  int   oq[$];
  exp_t mon_e;

  int m_base, m_ref, m_highs, m_busy_end;
  bit m_armed, m_fired;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit s_at(input int c);
    if (c < m_base + 2 || c - 2 >= HIST) return 1'b0;
    return pin_hist[c-2];
  endfunction

  function automatic int sat(input int v);
    return (v > TO) ? TO : v;
  endfunction

  task automatic model_init();
    m_base     = cyc;
    m_ref      = cyc;
    m_highs    = 0;
    m_busy_end = -100;
    m_armed    = 1'b0;
    m_fired    = 1'b0;
  endtask

  // Spec-level view: measurement runs from one synchronized rise to the next,
  // duty = round(10*H/P), result 5 cycles after a captured rise.
  task automatic model_step();
    int   c, p, h;
    bit   s, busy;
    exp_t e;
    c    = cyc;
    s    = s_at(c);
    busy = (c <= m_busy_end);
    if (s && !s_at(c - 1)) begin
      if (busy) begin
        oq.push_back(c + 1);
      end else if (!m_armed) begin
        m_armed = 1'b1;
      end else begin
        p = sat(c - m_ref);
        h = sat(m_highs);
        e.cyc = c + 5; e.duty = (20 * h + p) / (2 * p); e.per = p; e.hi = h; e.tmo = 1'b0;
        vq.push_back(e);
        m_busy_end = c + 4;
      end
      m_ref   = c;
      m_highs = 1;
      m_fired = 1'b0;
    end else begin
      if (!busy && !m_fired && (c - m_ref) >= TO) begin
        e.cyc = c + 1; e.duty = s ? 10 : 0; e.per = 0; e.hi = 0; e.tmo = 1'b1;
        vq.push_back(e);
        m_fired = 1'b1;
        m_armed = 1'b0;
      end
      if (s) m_highs++;
    end
  endtask

  // Monitor and model share one process so checking of cycle c precedes predictions for c+1.
  always @(negedge clk) begin
    if (cyc < HIST) pin_hist[cyc] = dut_if.ui_pwm_in;
    if (dut_if.uo_timeout) tmo_seen++;
    if (dut_if.uo_overrun) ovr_seen++;
    if (sb_on) begin
      if (vq.size() > 0 && vq[0].cyc == cyc) begin
        mon_e = vq.pop_front();
        check("valid_pulse", dut_if.uo_valid, 1);
        check("timeout_pulse", dut_if.uo_timeout, mon_e.tmo);
        check("duty", dut_if.uo_duty, mon_e.duty);
        check("period", dut_if.uo_period, mon_e.per);
        check("high", dut_if.uo_high, mon_e.hi);
      end else if (dut_if.uo_valid || dut_if.uo_timeout) begin
        check("spurious_valid_or_timeout", {dut_if.uo_valid, dut_if.uo_timeout}, 0);
      end
      if (oq.size() > 0 && oq[0] == cyc) begin
        void'(oq.pop_front());
        check("overrun_pulse", dut_if.uo_overrun, 1);
      end else if (dut_if.uo_overrun) begin
        check("spurious_overrun", dut_if.uo_overrun, 0);
      end
    end
    if (model_on && !rst) model_step();
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pwm(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < per; i++) begin
        dut_if.ui_pwm_in = (i < hi);
        step(1);
      end
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    model_on = 1'b0;
    vq.delete();
    oq.delete();
    #1;
    check("rst_duty", dut_if.uo_duty, 0);
    check("rst_period", dut_if.uo_period, 0);
    check("rst_high", dut_if.uo_high, 0);
    check("rst_valid", dut_if.uo_valid, 0);
    check("rst_overrun", dut_if.uo_overrun, 0);
    check("rst_timeout", dut_if.uo_timeout, 0);
    step(3);
    rst = 1'b0;
    model_init();
    model_on = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0, p, h, frozen_err, pulse_cnt, waited;
    logic [3:0]       snap_duty;
    logic [CNT_W-1:0] snap_per, snap_hi;

    dut_if.ena       = 1'b1;
    dut_if.ui_pwm_in = 1'b0;
    sb_on            = 1'b1;
    step(2);
    do_reset();

    // Nominal 50 % waveform; the first rise only arms.
    drive_pwm(10, 5, 20);

    // Rounding cases.
    drive_pwm(7, 2, 4);
    drive_pwm(10, 3, 4);
    drive_pwm(20, 1, 4);

    // Period 3: every other rise lands in DIV.
    ovr0 = ovr_seen;
    drive_pwm(3, 1, 10);
    dut_if.ui_pwm_in = 1'b0;
    step(8);
    check("overrun_count_p3", ovr_seen - ovr0, 5);

    // Random periods, including some short enough to overrun.
    for (int i = 0; i < 150; i++) begin
      p = ($urandom_range(9, 0) == 0) ? int'($urandom_range(4, 2)) : int'($urandom_range(30, 5));
      h = int'($urandom_range(p - 1, 1));
      drive_pwm(p, h, 1);
    end

    // Stuck low, then stuck high, then PWM again.
    check("no_timeout_before_stuck", tmo_seen, 0);
    dut_if.ui_pwm_in = 1'b0;
    step(TO + 40);
    check("timeouts_after_stuck_low", tmo_seen, 1);
    dut_if.ui_pwm_in = 1'b1;
    step(TO + 40);
    check("timeouts_after_stuck_high", tmo_seen, 2);
    drive_pwm(10, 5, 5);

    // Reset two cycles into DIV.
    dut_if.ui_pwm_in = 1'b0;
    step(10);
    dut_if.ui_pwm_in = 1'b1;
    step(4);
    do_reset();
    drive_pwm(10, 4, 6);
    dut_if.ui_pwm_in = 1'b0;
    step(8);

    // Enable gating; checked directly rather than through the model.
    sb_on    = 1'b0;
    model_on = 1'b0;
    vq.delete();
    oq.delete();
    frozen_err = 0;
    pulse_cnt  = 0;
    fork
      drive_pwm(10, 3, 12);
      begin
        step(13);
        dut_if.ena = 1'b0;
        step(1);
        snap_duty = dut_if.uo_duty;
        snap_per  = dut_if.uo_period;
        snap_hi   = dut_if.uo_high;
        for (int i = 0; i < 30; i++) begin
          if (dut_if.uo_valid || dut_if.uo_overrun || dut_if.uo_timeout) pulse_cnt++;
          if (dut_if.uo_duty !== snap_duty || dut_if.uo_period !== snap_per ||
              dut_if.uo_high !== snap_hi) frozen_err++;
          step(1);
        end
        check("ena_low_pulses", pulse_cnt, 0);
        check("ena_low_frozen", frozen_err, 0);
        dut_if.ena = 1'b1;
        step(25);
        waited = 0;
        while (!dut_if.uo_valid && waited < 40) begin
          step(1);
          waited++;
        end
        check("ena_resume_valid", dut_if.uo_valid, 1);
        check("ena_resume_duty", dut_if.uo_duty, 3);
        check("ena_resume_period", dut_if.uo_period, 10);
        check("ena_resume_high", dut_if.uo_high, 3);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
